// File: rtl/axi_4_lite_req_arbiter_if.sv
// Bundle of the two-client request port and the AXI4-Lite master port of the arbiter.
// The master modport is the arbiter's view; the slave modport is the clients-plus-register-file view.
interface axi_4_lite_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [1:0]              req_valid;
    logic [1:0]              req_we;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*DATA_WIDTH-1:0] req_wdata;
    logic [2*STRB_WIDTH-1:0] req_wstrb;
    logic [1:0]              req_ack;
    logic [DATA_WIDTH-1:0]   req_rdata;
    logic [1:0]              req_resp;
    logic [1:0]              grant;
    logic                    busy;

    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [2:0]              m_axi_awprot;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [STRB_WIDTH-1:0]   m_axi_wstrb;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [2:0]              m_axi_arprot;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ack, req_rdata, req_resp, grant, busy,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        input  m_axi_wready,
        input  m_axi_bvalid, m_axi_bresp,
        output m_axi_bready,
        output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
        output m_axi_rready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ack, req_rdata, req_resp, grant, busy,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input  m_axi_bready,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_4_lite_req_arbiter.sv
// Round-robin front end letting two clients share one AXI4-Lite slave, one transaction at a time.
// state  | meaning
// IDLE   | waiting for a request; picks winner, latches its fields
// WRITE  | AW and W outstanding, each dropped on its own handshake
// WRESP  | waiting for B
// RADDR  | ARVALID held until ARREADY
// RDATA  | RREADY high, waiting for R
// DONE   | one-cycle REQ_ACK to the owner, requests ignored
module axi_4_lite_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                     i_aclk,
    input  logic                     i_areset,
    axi_4_lite_req_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_ptr;
    logic [1:0]            r_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [1:0]            r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;

    logic                  w_any;
    logic                  w_win;
    logic                  w_win_we;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_wdata;
    logic [STRB_WIDTH-1:0] w_win_wstrb;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_aw_ok;
    logic                  w_w_ok;

    assign w_any = |bus.req_valid;
    // The pointer client wins when it asks; otherwise whichever client is asking.
    assign w_win = bus.req_valid[r_ptr] ? r_ptr : ~r_ptr;

    assign w_win_we    = w_win ? bus.req_we[1] : bus.req_we[0];
    assign w_win_addr  = w_win ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : bus.req_addr[ADDR_WIDTH-1:0];
    assign w_win_wdata = w_win ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : bus.req_wdata[DATA_WIDTH-1:0];
    assign w_win_wstrb = w_win ? bus.req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                               : bus.req_wstrb[STRB_WIDTH-1:0];

    assign w_aw_hs = r_awvalid & bus.m_axi_awready;
    assign w_w_hs  = r_wvalid  & bus.m_axi_wready;
    assign w_b_hs  = r_bready  & bus.m_axi_bvalid;
    assign w_ar_hs = r_arvalid & bus.m_axi_arready;
    assign w_r_hs  = r_rready  & bus.m_axi_rvalid;

    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_w_ok  = r_w_done  | w_w_hs;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state   <= S_IDLE;
            r_ptr     <= 1'b0;
            r_grant   <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ack     <= 2'b00;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_win ? 2'b10 : 2'b01;
                        r_ptr     <= ~w_win;
                        r_addr    <= w_win_addr;
                        r_wdata   <= w_win_wdata;
                        r_wstrb   <= w_win_wstrb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (w_win_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_bready  <= 1'b1;
                            r_state   <= S_WRITE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // BREADY is already up here, so an early B is taken without a WRESP cycle.
                    if (w_aw_ok && w_w_ok) begin
                        if (w_b_hs) begin
                            r_resp   <= bus.m_axi_bresp;
                            r_rdata  <= '0;
                            r_bready <= 1'b0;
                            r_ack    <= r_grant;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (w_b_hs) begin
                        r_resp   <= bus.m_axi_bresp;
                        r_rdata  <= '0;
                        r_bready <= 1'b0;
                        r_ack    <= r_grant;
                        r_state  <= S_DONE;
                    end
                end
                S_RADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (w_r_hs) begin
                        r_rdata  <= bus.m_axi_rdata;
                        r_resp   <= bus.m_axi_rresp;
                        r_rready <= 1'b0;
                        r_ack    <= r_grant;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack   = r_ack;
    assign bus.req_rdata = r_rdata;
    assign bus.req_resp  = r_resp;
    assign bus.grant     = r_grant;
    assign bus.busy      = (r_state != S_IDLE);

    assign bus.m_axi_awvalid = r_awvalid;
    assign bus.m_axi_awaddr  = r_addr;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_wvalid  = r_wvalid;
    assign bus.m_axi_wdata   = r_wdata;
    assign bus.m_axi_wstrb   = r_wstrb;
    assign bus.m_axi_bready  = r_bready;
    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_araddr  = r_addr;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_4_lite_req_arbiter.sv
// Bench for axi_4_lite_req_arbiter: a wait-state-programmable register-file slave, a
// transaction-level model checked every cycle, and directed tests with literal expectations.
module tb_axi_4_lite_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk;
    logic rst;

    axi_4_lite_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

    axi_4_lite_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) u_dut (
        .i_aclk   (clk),
        .i_areset (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int s_aw_wait = 0;
    int s_w_wait  = 0;
    int s_b_wait  = 0;
    int s_ar_wait = 0;
    int s_r_wait  = 0;
    logic [1:0] s_bresp = 2'b00;
    logic [1:0] s_rresp = 2'b00;

    int b_count     = 0;
    int aw_only     = 0;
    int viol_rready = 0;
    int viol_drop   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave register file: 16 words, per-channel ready/valid wait counts from s_*_wait.
    initial begin
        logic [31:0] s_mem [16];
        int aw_c, w_c, ar_c, b_c, r_c;
        logic have_aw, have_w, b_pend, r_pend;
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic aw_hold, w_hold, ar_hold;
        logic [31:0] aw_a, ar_a, w_d;
        logic [3:0] w_s;
        for (int i = 0; i < 16; i++) s_mem[i] = '0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        aw_a = '0; ar_a = '0; w_d = '0; w_s = '0;
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_arready = 0;
        bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
        bus.m_axi_rvalid = 0; bus.m_axi_rresp = 0; bus.m_axi_rdata = 0;
        forever begin
            @(negedge clk);
            aw_hs = bus.m_axi_awvalid & bus.m_axi_awready;
            w_hs  = bus.m_axi_wvalid  & bus.m_axi_wready;
            b_hs  = bus.m_axi_bvalid  & bus.m_axi_bready;
            ar_hs = bus.m_axi_arvalid & bus.m_axi_arready;
            r_hs  = bus.m_axi_rvalid  & bus.m_axi_rready;
            if (!rst) begin
                if (aw_hold && !bus.m_axi_awvalid) viol_drop++;
                if (w_hold && !bus.m_axi_wvalid) viol_drop++;
                if (ar_hold && !bus.m_axi_arvalid) viol_drop++;
                if (r_pend && !bus.m_axi_rready) viol_rready++;
                if (!bus.m_axi_awvalid && bus.m_axi_wvalid) aw_only++;
                if (b_hs) b_count++;
            end
            aw_hold = bus.m_axi_awvalid & ~bus.m_axi_awready;
            w_hold  = bus.m_axi_wvalid  & ~bus.m_axi_wready;
            ar_hold = bus.m_axi_arvalid & ~bus.m_axi_arready;
            if (aw_hs) aw_a = bus.m_axi_awaddr;
            if (w_hs) begin w_d = bus.m_axi_wdata; w_s = bus.m_axi_wstrb; end
            if (ar_hs) ar_a = bus.m_axi_araddr;
            @(posedge clk);
            #1;
            if (rst) begin
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
                have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
                aw_hold = 0; w_hold = 0; ar_hold = 0;
                bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_arready = 0;
                bus.m_axi_bvalid = 0; bus.m_axi_rvalid = 0;
            end else begin
                if (aw_hs) have_aw = 1;
                if (w_hs) have_w = 1;
                if (have_aw && have_w) begin
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) s_mem[aw_a[5:2]][b*8 +: 8] = w_d[b*8 +: 8];
                    have_aw = 0; have_w = 0; b_pend = 1; b_c = 0;
                end
                if (b_hs) b_pend = 0;
                if (ar_hs) begin r_pend = 1; r_c = 0; end
                if (r_hs) r_pend = 0;
                if (bus.m_axi_awvalid) begin bus.m_axi_awready = (aw_c >= s_aw_wait); aw_c++; end
                else begin bus.m_axi_awready = 0; aw_c = 0; end
                if (bus.m_axi_wvalid) begin bus.m_axi_wready = (w_c >= s_w_wait); w_c++; end
                else begin bus.m_axi_wready = 0; w_c = 0; end
                if (bus.m_axi_arvalid) begin bus.m_axi_arready = (ar_c >= s_ar_wait); ar_c++; end
                else begin bus.m_axi_arready = 0; ar_c = 0; end
                if (b_pend) begin
                    bus.m_axi_bvalid = (b_c >= s_b_wait); bus.m_axi_bresp = s_bresp; b_c++;
                end else bus.m_axi_bvalid = 0;
                if (r_pend) begin
                    bus.m_axi_rvalid = (r_c >= s_r_wait); bus.m_axi_rresp = s_rresp;
                    bus.m_axi_rdata = s_mem[ar_a[5:2]]; r_c++;
                end else bus.m_axi_rvalid = 0;
            end
        end
    end

    // Transaction-level model: who should own the bus this cycle and what its ack must carry.
    initial begin
        logic [31:0] m_mem [16];
        int owner, ptr;
        bit ack_seen;
        bit e_we;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0] e_wstrb;
        logic [1:0] e_resp, e_grant;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        owner = -1; ptr = 0; ack_seen = 0;
        e_we = 0; e_addr = 0; e_wdata = 0; e_rdata = 0; e_wstrb = 0; e_resp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_ctrl", 64'({bus.req_ack, bus.grant, bus.busy, bus.m_axi_awvalid,
                    bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready}), 64'd0);
                chk("reset_data", 64'(bus.m_axi_awaddr | bus.m_axi_araddr | bus.m_axi_wdata
                    | bus.req_rdata | 32'(bus.m_axi_wstrb) | 32'(bus.req_resp)), 64'd0);
                owner = -1; ptr = 0; ack_seen = 0;
            end else begin
                e_grant = (owner == 1) ? 2'b10 : ((owner == 0) ? 2'b01 : 2'b00);
                chk("grant", 64'(bus.grant), 64'(e_grant));
                chk("busy", 64'(bus.busy), 64'(owner >= 0));
                chk("prot", 64'({bus.m_axi_awprot, bus.m_axi_arprot}), 64'd0);
                if (owner >= 0) begin
                    if (bus.m_axi_awvalid || bus.m_axi_wvalid)
                        chk("write_on_read", 64'(e_we), 64'd1);
                    if (bus.m_axi_arvalid) chk("read_on_write", 64'(e_we), 64'd0);
                    if (bus.m_axi_awvalid) chk("awaddr", 64'(bus.m_axi_awaddr), 64'(e_addr));
                    if (bus.m_axi_wvalid) begin
                        chk("wdata", 64'(bus.m_axi_wdata), 64'(e_wdata));
                        chk("wstrb", 64'(bus.m_axi_wstrb), 64'(e_wstrb));
                    end
                    if (bus.m_axi_arvalid) chk("araddr", 64'(bus.m_axi_araddr), 64'(e_addr));
                    if (bus.req_ack != 2'b00) begin
                        chk("ack_owner", 64'(bus.req_ack), 64'(e_grant));
                        chk("ack_rdata", 64'(bus.req_rdata), 64'(e_rdata));
                        chk("ack_resp", 64'(bus.req_resp), 64'(e_resp));
                        ack_seen = 1;
                    end
                end else begin
                    chk("ack_idle", 64'(bus.req_ack), 64'd0);
                end
                if (ack_seen) begin
                    owner = -1; ack_seen = 0;
                end else if (owner < 0 && bus.req_valid != 2'b00) begin
                    owner   = bus.req_valid[ptr] ? ptr : 1 - ptr;
                    ptr     = 1 - owner;
                    e_we    = bus.req_we[owner];
                    e_addr  = bus.req_addr[owner*32 +: 32];
                    e_wdata = bus.req_wdata[owner*32 +: 32];
                    e_wstrb = bus.req_wstrb[owner*4 +: 4];
                    if (e_we) begin
                        for (int b = 0; b < 4; b++)
                            if (e_wstrb[b]) m_mem[e_addr[5:2]][b*8 +: 8] = e_wdata[b*8 +: 8];
                        e_rdata = '0;
                        e_resp  = s_bresp;
                    end else begin
                        e_rdata = m_mem[e_addr[5:2]];
                        e_resp  = s_rresp;
                    end
                end
            end
        end
    end

    task automatic do_req(input int c, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic [1:0] resp,
                          output int lat, output logic [1:0] g);
        bit found;
        found = 0; lat = 0; g = 2'b00; rdata = '0; resp = 2'b00;
        bus.req_we[c] = we;
        bus.req_addr[c*32 +: 32] = addr;
        bus.req_wdata[c*32 +: 32] = wdata;
        bus.req_wstrb[c*4 +: 4] = strb;
        bus.req_valid[c] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.grant != 2'b00) begin
                lat++;
                if (g == 2'b00) g = bus.grant;
            end
            if (bus.req_ack[c]) begin
                found = 1; rdata = bus.req_rdata; resp = bus.req_resp;
                break;
            end
        end
        chk("ack_arrived", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid[c] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd1;
        logic [1:0] rs, g;
        int lat, n, b0, a0;
        int order [4];
        rst = 1'b1;
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        do_req(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, rd, rs, lat, g);
        chk("wr0_resp", 64'(rs), 64'd0);
        chk("wr0_grant", 64'(g), 64'h1);
        chk("wr0_latency", 64'(lat), 64'd3);
        do_req(0, 0, 32'h4, 32'h0, 4'h0, rd, rs, lat, g);
        chk("rd0_data", 64'(rd), 64'hDEADBEEF);
        chk("rd0_resp", 64'(rs), 64'd0);
        chk("rd0_latency", 64'(lat), 64'd3);

        do_req(0, 1, 32'h4, 32'h11223344, 4'b0011, rd, rs, lat, g);
        chk("partial_wr_rdata", 64'(rd), 64'd0);
        do_req(0, 0, 32'h4, 32'h0, 4'h0, rd, rs, lat, g);
        chk("partial_rd_data", 64'(rd), 64'hDEAD3344);

        do_req(1, 1, 32'h10, 32'hCAFEF00D, 4'hF, rd, rs, lat, g);
        chk("wr1_grant", 64'(g), 64'h2);

        // Both clients hold their requests across four completions.
        bus.req_we[0] = 1'b1; bus.req_addr[31:0] = 32'h8;
        bus.req_wdata[31:0] = 32'h00001111; bus.req_wstrb[3:0] = 4'hF;
        bus.req_we[1] = 1'b0; bus.req_addr[63:32] = 32'h10;
        bus.req_valid = 2'b11;
        n = 0; rd1 = '0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            if (bus.req_ack != 2'b00) begin
                order[n] = bus.req_ack[1] ? 1 : 0;
                if (bus.req_ack[1]) rd1 = bus.req_rdata;
                n++;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        chk("rr_count", 64'(n), 64'd4);
        chk("rr_order0", 64'(order[0]), 64'd0);
        chk("rr_order1", 64'(order[1]), 64'd1);
        chk("rr_order2", 64'(order[2]), 64'd0);
        chk("rr_order3", 64'(order[3]), 64'd1);
        chk("rr_rd1_data", 64'(rd1), 64'hCAFEF00D);

        s_w_wait = 3;
        b0 = b_count; a0 = aw_only;
        do_req(1, 1, 32'h14, 32'h55AA55AA, 4'hF, rd, rs, lat, g);
        chk("split_aw_only_cycles", 64'(aw_only - a0), 64'd3);
        chk("split_b_count", 64'(b_count - b0), 64'd1);
        s_w_wait = 0;

        s_r_wait = 5; s_rresp = 2'b10;
        do_req(0, 0, 32'h14, 32'h0, 4'h0, rd, rs, lat, g);
        chk("err_rd_resp", 64'(rs), 64'h2);
        chk("err_rd_data", 64'(rd), 64'h55AA55AA);
        chk("err_rd_latency", 64'(lat), 64'd8);
        s_r_wait = 0; s_rresp = 2'b00;

        s_bresp = 2'b11;
        do_req(1, 1, 32'h18, 32'h12345678, 4'hF, rd, rs, lat, g);
        chk("err_wr_resp", 64'(rs), 64'h3);
        s_bresp = 2'b00;

        // Reset lands in the middle of a stalled write.
        s_aw_wait = 10; s_w_wait = 10;
        bus.req_we[0] = 1'b1; bus.req_addr[31:0] = 32'h20;
        bus.req_wdata[31:0] = 32'hFFFFFFFF; bus.req_wstrb[3:0] = 4'hF;
        bus.req_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_busy", 64'({bus.busy, bus.m_axi_awvalid, bus.m_axi_wvalid}), 64'h7);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valids", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}), 64'd0);
        chk("async_rst_busy_grant", 64'({bus.busy, bus.grant}), 64'd0);
        bus.req_valid = 2'b00;
        s_aw_wait = 0; s_w_wait = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(0, 1, 32'h24, 32'h0BADF00D, 4'hF, rd, rs, lat, g);
        chk("post_rst_grant", 64'(g), 64'h1);
        chk("post_rst_resp", 64'(rs), 64'd0);
        chk("post_rst_latency", 64'(lat), 64'd3);
        do_req(1, 0, 32'h24, 32'h0, 4'h0, rd, rs, lat, g);
        chk("post_rst_rd_data", 64'(rd), 64'h0BADF00D);

        repeat (3) @(negedge clk);
        chk("rready_held", 64'(viol_rready), 64'd0);
        chk("valid_held", 64'(viol_drop), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
